cam_capture_fb: RTL and testbench

Parametrised OV7670 frame-capture engine between the camera pins (pclk domain) and the dual-port framebuffer write port. It assembles RGB565 byte pairs into pixels of a selectable output format, computes row/column-based framebuffer addresses with clipping, and supports continuous or single-shot capture through a request handshake. Line-length and frame-height faults are flagged rather than corrupting the addressing.

---
 rtl/cam_capture_fb_if.sv | 14 +
 rtl/cam_capture_fb.sv | 204 ++++++++++++++++++++
 tb/tb_cam_capture_fb.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cam_capture_fb_if.sv
// Framebuffer write port driven by cam_capture_fb.
// px_wr is a valid-only strobe: address and data are meaningful only while px_wr=1,
// and the framebuffer accepts every write (there is no ready).
interface cam_capture_fb_if #(
   parameter int AW = 15,
   parameter int DW = 8
);
   logic [AW-1:0] mem_px_addr;
   logic [DW-1:0] mem_px_data;
   logic          px_wr;

   modport master (output mem_px_addr, output mem_px_data, output px_wr);
   modport slave  (input  mem_px_addr, input  mem_px_data, input  px_wr);
endinterface

// File: rtl/cam_capture_fb.sv
// OV7670 frame capture into a framebuffer write port, single pclk domain.
// Define CAM_CAPTURE_ERR_EN to build the err_line/err_frame detectors; otherwise both read 0.
module cam_capture_fb #(
   parameter int AW      = 15,
   parameter int DW      = 8,
   parameter int H_PIX   = 160,
   parameter int V_LINES = 120,
   parameter int XW      = 8,
   parameter int YW      = 8
) (
   input  logic             pclk,
   input  logic             rst,
   input  logic             vsync,
   input  logic             href,
   input  logic [7:0]       px_data,
   input  logic             cap_mode,
   input  logic             cap_req,
   cam_capture_fb_if.master mem,
   output logic             busy,
   output logic             frame_done,
   output logic [YW-1:0]    row,
   output logic [XW-1:0]    col,
   output logic [15:0]      frame_cnt,
   output logic             err_line,
   output logic             err_frame,
   output logic [2:0]       fsm_state_o
);
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WAIT_VS = 3'd1,
      LINE    = 3'd2,
      HI      = 3'd3,
      LO      = 3'd4
   } state_t;

   localparam logic [XW-1:0] H_MAX  = XW'(H_PIX);
   localparam logic [YW-1:0] V_MAX  = YW'(V_LINES);
   localparam logic [AW-1:0] H_STEP = AW'(H_PIX);

   state_t        state_q, state_d;
   logic          vsync_q, href_q;
   logic [YW-1:0] row_q, row_d;
   logic [XW-1:0] col_q, col_d;
   logic [AW-1:0] base_q, base_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [7:0]    hi_q, hi_d;
   logic [DW-1:0] data_q, data_d;
   logic          wr_q, wr_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [15:0]   cnt_q, cnt_d;
   logic          vs_fall, vs_rise, href_fall, in_frame;

   function automatic logic [DW-1:0] conv(input logic [15:0] p);
      logic [15:0] r;
      r = p;
      if (DW == 8)       r = {8'h00, p[15:13], p[10:8], p[4:3]};
      else if (DW == 12) r = {4'h0, p[15:12], p[10:7], p[4:1]};
      return r[DW-1:0];
   endfunction

   assign vs_fall   = vsync_q & ~vsync;
   assign vs_rise   = ~vsync_q & vsync;
   assign href_fall = href_q & ~href;
   assign in_frame  = (state_q == LINE) || (state_q == HI) || (state_q == LO);

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      base_d  = base_q;
      hi_d    = hi_q;
      addr_d  = addr_q;
      data_d  = data_q;
      wr_d    = 1'b0;
      busy_d  = busy_q;
      done_d  = 1'b0;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (!cap_mode || cap_req) state_d = WAIT_VS;
         end
         WAIT_VS: begin
            if (vs_fall) begin
               row_d   = '0;
               col_d   = '0;
               base_d  = '0;
               busy_d  = 1'b1;
               state_d = LINE;
            end
         end
         LINE: begin
            if (href) begin
               hi_d    = px_data;
               state_d = LO;
            end
         end
         LO: begin
            if (href) begin
               if (col_q < H_MAX && row_q < V_MAX) begin
                  wr_d   = 1'b1;
                  addr_d = base_q + AW'(col_q);
                  data_d = conv({hi_q, px_data});
               end
               if (col_q != H_MAX) col_d = col_q + 1'b1;
               state_d = HI;
            end else begin
               state_d = LINE;
            end
         end
         HI: begin
            if (href) begin
               hi_d    = px_data;
               state_d = LO;
            end else begin
               state_d = LINE;
            end
         end
         default: state_d = IDLE;
      endcase
      // Line end is accounted before frame end so the frame check sees the final row.
      if (in_frame && href_fall) begin
         col_d = '0;
         if (row_q != V_MAX) begin
            row_d  = row_q + 1'b1;
            base_d = base_q + H_STEP;
         end
      end
      if (in_frame && vs_rise) begin
         done_d  = 1'b1;
         cnt_d   = cnt_q + 16'd1;
         busy_d  = 1'b0;
         state_d = cap_mode ? IDLE : WAIT_VS;
      end
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         state_q <= IDLE;
         vsync_q <= 1'b1;
         href_q  <= 1'b0;
         row_q   <= '0;
         col_q   <= '0;
         base_q  <= '0;
         hi_q    <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         wr_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         vsync_q <= vsync;
         href_q  <= href;
         row_q   <= row_d;
         col_q   <= col_d;
         base_q  <= base_d;
         hi_q    <= hi_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         wr_q    <= wr_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef CAM_CAPTURE_ERR_EN
   // col saturates at H_PIX, so ovf_q remembers that a pixel arrived past the last column.
   logic err_line_q, err_frame_q, ovf_q;

   always_ff @(posedge pclk) begin
      if (rst || (state_q == WAIT_VS && vs_fall)) begin
         err_line_q  <= 1'b0;
         err_frame_q <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         if (state_q == LO && href && col_q == H_MAX) ovf_q <= 1'b1;
         if (in_frame && href_fall) begin
            ovf_q <= 1'b0;
            if (col_q != H_MAX || ovf_q || state_q == LO) err_line_q <= 1'b1;
         end
         if (in_frame && vs_rise && row_d != V_MAX) err_frame_q <= 1'b1;
      end
   end

   assign err_line  = err_line_q;
   assign err_frame = err_frame_q;
`else
   assign err_line  = 1'b0;
   assign err_frame = 1'b0;
`endif

   assign mem.mem_px_addr = addr_q;
   assign mem.mem_px_data = data_q;
   assign mem.px_wr       = wr_q;
   assign busy            = busy_q;
   assign frame_done      = done_q;
   assign row             = row_q;
   assign col             = col_q;
   assign frame_cnt       = cnt_q;
   assign fsm_state_o     = state_q;
endmodule

// File: tb/tb_cam_capture_fb.sv
// Bench for cam_capture_fb: two instances (DW=8 and DW=16) share one camera stream
// with a reduced 20x6 geometry; a table of frames plus latency and reset sequences.
module tb_cam_capture_fb;
   localparam int AW = 15;
   localparam int H  = 20;
   localparam int V  = 6;
`ifdef CAM_CAPTURE_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic       pclk = 1'b0;
   logic       rst, vsync, href, cap_mode, cap_req;
   logic [7:0] px_data;

   logic        busy8, done8, el8, ef8, busy16, done16, el16, ef16;
   logic [7:0]  row8, col8, row16, col16;
   logic [15:0] cnt8, cnt16;
   logic [2:0]  st8, st16;

   cam_capture_fb_if #(.AW(AW), .DW(8))  m8 ();
   cam_capture_fb_if #(.AW(AW), .DW(16)) m16 ();

   cam_capture_fb #(.AW(AW), .DW(8), .H_PIX(H), .V_LINES(V), .XW(8), .YW(8)) dut8 (
      .pclk(pclk), .rst(rst), .vsync(vsync), .href(href), .px_data(px_data),
      .cap_mode(cap_mode), .cap_req(cap_req), .mem(m8.master),
      .busy(busy8), .frame_done(done8), .row(row8), .col(col8), .frame_cnt(cnt8),
      .err_line(el8), .err_frame(ef8), .fsm_state_o(st8));

   cam_capture_fb #(.AW(AW), .DW(16), .H_PIX(H), .V_LINES(V), .XW(8), .YW(8)) dut16 (
      .pclk(pclk), .rst(rst), .vsync(vsync), .href(href), .px_data(px_data),
      .cap_mode(cap_mode), .cap_req(cap_req), .mem(m16.master),
      .busy(busy16), .frame_done(done16), .row(row16), .col(col16), .frame_cnt(cnt16),
      .err_line(el16), .err_frame(ef16), .fsm_state_o(st16));

   // clock / reset
   initial forever #5 pclk = ~pclk;

   // scoreboard
   logic [AW+15:0] exp_q[$];
   int checks = 0, errors = 0, wr_cnt = 0, done_cnt = 0;
   logic prev_wr = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] to8(input logic [15:0] p);
      return {p[15:13], p[10:8], p[4:3]};
   endfunction

   always @(negedge pclk) begin
      logic [AW+15:0] e;
      if (m8.px_wr) begin
         wr_cnt++;
         chk("px_wr_back_to_back", 32'(prev_wr), 0);
         chk("write_expected", 32'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("addr8", 32'(m8.mem_px_addr), 32'(e[AW+15:16]));
            chk("data8", 32'(m8.mem_px_data), 32'(to8(e[15:0])));
            chk("wr16", 32'(m16.px_wr), 1);
            chk("addr16", 32'(m16.mem_px_addr), 32'(e[AW+15:16]));
            chk("data16", 32'(m16.mem_px_data), 32'(e[15:0]));
         end
      end
      if (done8) done_cnt++;
      prev_wr = m8.px_wr;
   end

   // drivers
   function automatic logic [15:0] pix(input int f, input int l, input int c, input bit pat);
      logic [7:0] a, b;
      a = 8'(c * 13 + l * 7 + f);
      b = 8'(c ^ (l << 3) ^ (f * 5));
      return pat ? 16'hF81F : {a, b};
   endfunction

   task automatic send_px(input int l, input int c, input logic [15:0] p, input bit cap);
      if (cap && c < H && l < V) exp_q.push_back({AW'(l * H + c), p});
      href = 1'b1;
      px_data = p[15:8];
      @(negedge pclk);
      px_data = p[7:0];
      @(negedge pclk);
   endtask

   task automatic line_gap();
      href = 1'b0;
      px_data = 8'h00;
      repeat (4) @(negedge pclk);
   endtask

   task automatic send_line(input int f, input int l, input int npix, input bit odd,
                            input bit pat, input bit cap);
      for (int c = 0; c < npix; c++) send_px(l, c, pix(f, l, c, pat), cap);
      if (odd) begin
         href = 1'b1;
         px_data = 8'hA5;
         @(negedge pclk);
      end
      line_gap();
   endtask

   task automatic frame_start();
      vsync = 1'b1;
      repeat (4) @(negedge pclk);
      vsync = 1'b0;
      repeat (2) @(negedge pclk);
   endtask

   typedef struct {
      int          lines;
      int          npix;
      bit          odd;
      bit          pat;
      bit          req;
      bit          mode_end;
      bit          cap;
      int          writes;
      int          dones;
      logic [15:0] cnt;
      logic [7:0]  row;
      bit          el;
      bit          ef;
      logic [2:0]  st;
   } rec_t;

   task automatic run_frame(input int f, input rec_t t);
      int w0, d0;
      w0 = wr_cnt;
      d0 = done_cnt;
      vsync = 1'b1;
      href = 1'b0;
      if (t.req) begin
         cap_req = 1'b1;
         @(negedge pclk);
         cap_req = 1'b0;
      end
      repeat (4) @(negedge pclk);
      vsync = 1'b0;
      repeat (3) @(negedge pclk);
      chk($sformatf("busy_mid_f%0d", f), 32'(busy8), 32'(t.cap));
      for (int l = 0; l < t.lines; l++) send_line(f, l, t.npix, t.odd, t.pat, t.cap);
      cap_mode = t.mode_end;
      vsync = 1'b1;
      @(negedge pclk);
      chk($sformatf("frame_done_f%0d", f), 32'(done8), 32'(t.cap));
      repeat (3) @(negedge pclk);
      chk($sformatf("writes_f%0d", f), 32'(wr_cnt - w0), 32'(t.writes));
      chk($sformatf("dones_f%0d", f), 32'(done_cnt - d0), 32'(t.dones));
      chk($sformatf("frame_cnt_f%0d", f), 32'(cnt8), 32'(t.cnt));
      chk($sformatf("row_f%0d", f), 32'(row8), 32'(t.row));
      chk($sformatf("col_f%0d", f), 32'(col8), 0);
      chk($sformatf("err_line_f%0d", f), 32'(el8), 32'(t.el));
      chk($sformatf("err_frame_f%0d", f), 32'(ef8), 32'(t.ef));
      chk($sformatf("busy_end_f%0d", f), 32'(busy8), 0);
      chk($sformatf("state_f%0d", f), 32'(st8), 32'(t.st));
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_addr"}, 32'(m8.mem_px_addr), 0);
      chk({tag, "_data8"}, 32'(m8.mem_px_data), 0);
      chk({tag, "_data16"}, 32'(m16.mem_px_data), 0);
      chk({tag, "_wr"}, 32'(m8.px_wr), 0);
      chk({tag, "_busy"}, 32'(busy8), 0);
      chk({tag, "_done"}, 32'(done8), 0);
      chk({tag, "_row"}, 32'(row8), 0);
      chk({tag, "_col"}, 32'(col8), 0);
      chk({tag, "_cnt"}, 32'(cnt8), 0);
      chk({tag, "_err_line"}, 32'(el8), 0);
      chk({tag, "_err_frame"}, 32'(ef8), 0);
      chk({tag, "_state"}, 32'(st8), 0);
   endtask

   rec_t tbl[12];
   rec_t again;

   initial begin
      //            lines npix odd pat req mend cap wr  dn cnt row el      ef      st
      tbl[0]  = '{6, 20, 0, 1, 0, 0, 1, 120, 1, 16'd1,  8'd6, 1'b0,   1'b0,   3'd1};
      tbl[1]  = '{6, 20, 0, 0, 0, 0, 1, 120, 1, 16'd2,  8'd6, 1'b0,   1'b0,   3'd1};
      tbl[2]  = '{6, 30, 0, 0, 0, 0, 1, 120, 1, 16'd3,  8'd6, ERR_EN, 1'b0,   3'd1};
      tbl[3]  = '{6, 20, 1, 0, 0, 0, 1, 120, 1, 16'd4,  8'd6, ERR_EN, 1'b0,   3'd1};
      tbl[4]  = '{4, 20, 0, 0, 0, 0, 1, 80,  1, 16'd5,  8'd4, 1'b0,   ERR_EN, 3'd1};
      tbl[5]  = '{8, 20, 0, 0, 0, 0, 1, 120, 1, 16'd6,  8'd6, 1'b0,   1'b0,   3'd1};
      tbl[6]  = '{6, 15, 0, 0, 0, 0, 1, 90,  1, 16'd7,  8'd6, ERR_EN, 1'b0,   3'd1};
      tbl[7]  = '{6, 20, 0, 0, 0, 1, 1, 120, 1, 16'd8,  8'd6, 1'b0,   1'b0,   3'd0};
      tbl[8]  = '{6, 20, 0, 0, 0, 1, 0, 0,   0, 16'd8,  8'd6, 1'b0,   1'b0,   3'd0};
      tbl[9]  = '{6, 20, 0, 0, 1, 1, 1, 120, 1, 16'd9,  8'd6, 1'b0,   1'b0,   3'd0};
      tbl[10] = '{6, 20, 0, 0, 0, 0, 0, 0,   0, 16'd9,  8'd6, 1'b0,   1'b0,   3'd1};
      tbl[11] = '{6, 20, 0, 0, 0, 0, 1, 120, 1, 16'd10, 8'd6, 1'b0,   1'b0,   3'd1};
      again   = '{6, 20, 0, 0, 0, 0, 1, 120, 1, 16'd1,  8'd6, 1'b0,   1'b0,   3'd1};

      rst = 1'b1;
      vsync = 1'b1;
      href = 1'b0;
      px_data = 8'h00;
      cap_mode = 1'b0;
      cap_req = 1'b0;
      repeat (3) @(negedge pclk);
      chk_zero("reset");
      rst = 1'b0;
      @(negedge pclk);

      for (int i = 0; i < 12; i++) run_frame(i, tbl[i]);

      // write latency at row 3, col 5 (address 3*20+5)
      frame_start();
      for (int l = 0; l < 3; l++) send_line(50, l, H, 1'b0, 1'b0, 1'b1);
      for (int c = 0; c < 5; c++) send_px(3, c, pix(50, 3, c, 1'b0), 1'b1);
      exp_q.push_back({AW'(65), 16'h1234});
      href = 1'b1;
      px_data = 8'h12;
      @(negedge pclk);
      chk("lat_wr_after_hi", 32'(m16.px_wr), 0);
      px_data = 8'h34;
      @(negedge pclk);
      chk("lat_wr_after_lo", 32'(m16.px_wr), 1);
      chk("lat_addr", 32'(m16.mem_px_addr), 65);
      chk("lat_data16", 32'(m16.mem_px_data), 32'h1234);
      chk("lat_data8", 32'(m8.mem_px_data), 32'h0A);
      for (int c = 6; c < H; c++) send_px(3, c, pix(50, 3, c, 1'b0), 1'b1);
      line_gap();
      for (int l = 4; l < V; l++) send_line(50, l, H, 1'b0, 1'b0, 1'b1);
      vsync = 1'b1;
      repeat (4) @(negedge pclk);
      chk("lat_frame_cnt", 32'(cnt8), 11);
      chk("lat_err_line", 32'(el8), 0);
      chk("lat_err_frame", 32'(ef8), 0);

      // reset in the middle of a frame, then a clean restart
      frame_start();
      for (int l = 0; l < 3; l++) send_line(60, l, H, 1'b0, 1'b0, 1'b1);
      chk("pre_rst_row", 32'(row8), 3);
      rst = 1'b1;
      repeat (2) @(negedge pclk);
      chk_zero("midrst");
      rst = 1'b0;
      repeat (5) @(negedge pclk);
      run_frame(70, again);

      chk("scoreboard_empty", 32'(exp_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
